// File: rtl/gpr_hilo_file_pkg.sv
// Shared constants and types for the GPR / HI-LO register file.
package gpr_hilo_file_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  localparam logic [REG_DATA_W-1:0] ZERO_WORD  = '0;
  localparam logic [REG_ADDR_W-1:0] REG_ADDR_0 = '0;

  // Source chosen by a GPR read port for its output word.
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_BYPASS,
    SRC_STORE
  } read_src_e;

endpackage

// File: rtl/gpr_read_port.sv
// One GPR read port: priority mux over reset, $0, writeback bypass, storage and disable.
// Bypass path is present only when GPR_HILO_BYPASS_EN is defined.
module gpr_read_port
  import gpr_hilo_file_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [DATA_W-1:0] stored,
  output logic [DATA_W-1:0] rdata
);

  read_src_e src;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    src = SRC_ZERO;
    if (rst || raddr == '0) begin
      src = SRC_ZERO;
`ifdef GPR_HILO_BYPASS_EN
    end else if (re && wb_we && wb_waddr == raddr) begin
      src = SRC_BYPASS;
`endif
    end else if (re) begin
      src = SRC_STORE;
    end
  end

  always_comb begin
    rdata = '0;
    case (src)
      SRC_BYPASS: rdata = wb_result;
      SRC_STORE:  rdata = stored;
      default:    rdata = '0;
    endcase
  end

`ifndef GPR_HILO_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_waddr, wb_result};
`endif

endmodule

// File: rtl/gpr_hilo_file.sv
// 32 x 32-bit GPR file plus HI/LO pair, written from MEM/WB, read by ID (GPR) and EX (HI/LO).
// Define GPR_HILO_BYPASS_EN for same-cycle write-to-read forwarding on all read paths.
module gpr_hilo_file
  import gpr_hilo_file_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              wb_whilo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] gpr [NUM_REGS];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // NOTE: the whole array is cleared on reset because software relies on zeroed GPRs; this rules out a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
    end else if (wb_we && wb_waddr != '0) begin
      gpr[wb_waddr] <= wb_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wb_whilo) begin
      hi_q <= wb_hi;
      lo_q <= wb_lo;
    end
  end

  gpr_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
    .rst       (rst),
    .re        (re1),
    .raddr     (raddr1),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_result (wb_result),
    .stored    (gpr[raddr1]),
    .rdata     (rdata1)
  );

  gpr_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
    .rst       (rst),
    .re        (re2),
    .raddr     (raddr2),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_result (wb_result),
    .stored    (gpr[raddr2]),
    .rdata     (rdata2)
  );

  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (rst) begin
      hi_o = '0;
      lo_o = '0;
`ifdef GPR_HILO_BYPASS_EN
    end else if (wb_whilo) begin
      hi_o = wb_hi;
      lo_o = wb_lo;
`endif
    end
  end

endmodule

// File: tb/tb_gpr_hilo_file.sv
// Directed self-checking bench for gpr_hilo_file; expectations follow GPR_HILO_BYPASS_EN if defined.
module tb_gpr_hilo_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_result;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks   = 0;
  int failures = 0;

`ifdef GPR_HILO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  gpr_hilo_file dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_result (wb_result),
    .wb_whilo  (wb_whilo),
    .wb_hi     (wb_hi),
    .wb_lo     (wb_lo),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1-2 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wb();
    wb_we = 1'b0; wb_waddr = '0; wb_result = '0;
    wb_whilo = 1'b0; wb_hi = '0; wb_lo = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_wb();
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    tick(); tick();
    rst = 1'b0;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd31;
    #1;
    check("reset_rdata1", rdata1, 32'h0);
    check("reset_rdata2", rdata2, 32'h0);
    check("reset_hi", hi_o, 32'h0);
    check("reset_lo", lo_o, 32'h0);

    // Populate gpr[5] and HI/LO, then reset for two cycles.
    wb_we = 1'b1; wb_waddr = 5'd5; wb_result = 32'h1234_5678;
    wb_whilo = 1'b1; wb_hi = 32'hAAAA_0000; wb_lo = 32'h0000_5555;
    tick();
    idle_wb();
    #1;
    check("pre_reset_gpr5", rdata1, 32'h1234_5678);
    check("pre_reset_hi", hi_o, 32'hAAAA_0000);
    rst = 1'b1;
    #1;
    check("in_reset_rdata1", rdata1, 32'h0);
    check("in_reset_hi", hi_o, 32'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("post_reset_gpr5", rdata1, 32'h0);
    check("post_reset_hi", hi_o, 32'h0);
    check("post_reset_lo", lo_o, 32'h0);

    // Write then read on both ports, then disable port 1.
    wb_we = 1'b1; wb_waddr = 5'd7; wb_result = 32'hDEAD_BEEF;
    tick();
    idle_wb();
    raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    check("gpr7_port1", rdata1, 32'hDEAD_BEEF);
    check("gpr7_port2", rdata2, 32'hDEAD_BEEF);
    re1 = 1'b0;
    #1;
    check("gpr7_re1_off", rdata1, 32'h0);
    check("gpr7_port2_indep", rdata2, 32'hDEAD_BEEF);
    re1 = 1'b1;

    // $0 stays zero, including the same-cycle read.
    wb_we = 1'b1; wb_waddr = 5'd0; wb_result = 32'hFFFF_FFFF;
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    check("r0_same_cycle_p1", rdata1, 32'h0);
    check("r0_same_cycle_p2", rdata2, 32'h0);
    tick();
    idle_wb();
    #1;
    check("r0_after_write", rdata1, 32'h0);

    // Bypass: gpr[9]=0x11 stored, overwritten with 0x22 while both ports read it.
    wb_we = 1'b1; wb_waddr = 5'd9; wb_result = 32'h11;
    tick();
    wb_result = 32'h22;
    raddr1 = 5'd9; raddr2 = 5'd9;
    #1;
    check("bypass_p1", rdata1, BYP ? 32'h22 : 32'h11);
    check("bypass_p2", rdata2, BYP ? 32'h22 : 32'h11);
    re1 = 1'b0;
    #1;
    check("bypass_re1_off", rdata1, 32'h0);
    re1 = 1'b1;
    tick();
    idle_wb();
    #1;
    check("after_bypass_p1", rdata1, 32'h22);
    check("after_bypass_p2", rdata2, 32'h22);

    // HI/LO write, same-cycle view, hold, and isolation from GPR writes.
    wb_whilo = 1'b1; wb_hi = 32'h3; wb_lo = 32'h4;
    #1;
    check("hilo_same_hi", hi_o, BYP ? 32'h3 : 32'h0);
    check("hilo_same_lo", lo_o, BYP ? 32'h4 : 32'h0);
    tick();
    wb_whilo = 1'b0; wb_hi = 32'hBAD0_BAD0; wb_lo = 32'hBAD1_BAD1;
    wb_we = 1'b1; wb_waddr = 5'd2; wb_result = 32'h99;
    #1;
    check("hilo_hold_hi", hi_o, 32'h3);
    check("hilo_hold_lo", lo_o, 32'h4);
    tick();
    idle_wb();
    raddr1 = 5'd2; raddr2 = 5'd7;
    #1;
    check("gpr_write_only_hi", hi_o, 32'h3);
    check("gpr_write_only_lo", lo_o, 32'h4);
    check("gpr2_written", rdata1, 32'h99);

    // Garbage on data/address while enables are low must not disturb state.
    wb_waddr = 5'd7; wb_result = 32'h0BAD_0BAD; wb_hi = 32'h1; wb_lo = 32'h2;
    tick();
    idle_wb();
    #1;
    check("no_we_gpr7", rdata2, 32'hDEAD_BEEF);
    check("no_whilo_hi", hi_o, 32'h3);

    // Reset on the same edge as a write: the write is discarded.
    rst = 1'b1;
    wb_we = 1'b1; wb_waddr = 5'd3; wb_result = 32'h55;
    tick();
    rst = 1'b0;
    idle_wb();
    raddr1 = 5'd3;
    #1;
    check("rst_mid_write_gpr3", rdata1, 32'h0);
    check("rst_mid_write_gpr7", rdata2, 32'h0);
    check("rst_mid_write_hi", hi_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
